// File: rtl/toggle_monitor.sv
// Measures toggle intervals of a fast (a_in) and slow (b_in) register and checks b ~= 2*a within TOL.
// Optional macro TOGGLE_MONITOR_INVERT_CHECK_EN: events that are not a full bitwise inversion force FAULT.
module toggle_monitor #(
  parameter int CNT_W = 16,
  parameter int TOL   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       a_in,
  input  logic [1:0]       b_in,
  input  logic             clear,
  output logic [CNT_W-1:0] a_period,
  output logic [CNT_W-1:0] b_period,
  output logic             a_valid,
  output logic             b_valid,
  output logic [1:0]       state,
  output logic             ovf
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MEASURE = 2'd1;
  localparam logic [1:0] LOCKED  = 2'd2;
  localparam logic [1:0] FAULT   = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W+1:0] TOL_EXT = (CNT_W+2)'(TOL);

  logic [1:0]       a_q, b_q;
  logic [CNT_W-1:0] cnt_a, cnt_b;
  logic             arm_a, arm_b, a_cap;
  logic             a_evt, b_evt, a_bad, b_bad, a_capt, b_capt;
  logic             ovf_nxt, ratio_ok;
  logic [CNT_W-1:0] a_new, b_new;
  logic [CNT_W+1:0] b_ext, a2_ext, diff;
  logic [1:0]       state_nxt;

  assign a_evt = (a_in != a_q);
  assign b_evt = (b_in != b_q);

`ifdef TOGGLE_MONITOR_INVERT_CHECK_EN
  assign a_bad = a_evt && (a_in != ~a_q);
  assign b_bad = b_evt && (b_in != ~b_q);
`else
  assign a_bad = 1'b0;
  assign b_bad = 1'b0;
`endif

  assign a_capt = a_evt && arm_a;
  assign b_capt = b_evt && arm_b;

  // Next counter value doubles as the captured period (interval = cnt + 1, saturating).
  assign a_new = (cnt_a == CNT_MAX) ? CNT_MAX : cnt_a + CNT_ONE;
  assign b_new = (cnt_b == CNT_MAX) ? CNT_MAX : cnt_b + CNT_ONE;

  assign ovf_nxt = ovf
                 | (!a_evt && (cnt_a >= CNT_MAX - CNT_ONE))
                 | (!b_evt && (cnt_b >= CNT_MAX - CNT_ONE));

  // Ratio uses the a_period register, i.e. the value before any same-cycle a capture.
  assign b_ext    = {2'b00, b_new};
  assign a2_ext   = {1'b0, a_period, 1'b0};
  assign diff     = (b_ext >= a2_ext) ? (b_ext - a2_ext) : (a2_ext - b_ext);
  assign ratio_ok = (diff <= TOL_EXT);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if ((arm_a || a_evt) && (arm_b || b_evt)) state_nxt = MEASURE;
      MEASURE: if (b_capt && a_cap) state_nxt = ratio_ok ? LOCKED : FAULT;
      LOCKED:  if ((b_capt && !ratio_ok) || ovf_nxt) state_nxt = FAULT;
      default: state_nxt = FAULT;
    endcase
    if ((state == MEASURE || state == LOCKED) && (a_bad || b_bad))
      state_nxt = FAULT;
    if ((state == IDLE) && ((a_bad && arm_a) || (b_bad && arm_b)))
      state_nxt = FAULT;
  end

  always_ff @(posedge clk) begin
    a_q <= a_in;
    b_q <= b_in;
    if (rst || clear) begin
      state    <= IDLE;
      cnt_a    <= '0;
      cnt_b    <= '0;
      a_period <= '0;
      b_period <= '0;
      a_valid  <= 1'b0;
      b_valid  <= 1'b0;
      ovf      <= 1'b0;
      arm_a    <= 1'b0;
      arm_b    <= 1'b0;
      a_cap    <= 1'b0;
    end else begin
      cnt_a   <= a_evt ? '0 : a_new;
      cnt_b   <= b_evt ? '0 : b_new;
      a_valid <= a_capt;
      b_valid <= b_capt;
      if (a_capt) a_period <= a_new;
      if (b_capt) b_period <= b_new;
      if (a_evt)  arm_a    <= 1'b1;
      if (b_evt)  arm_b    <= 1'b1;
      if (a_capt) a_cap    <= 1'b1;
      ovf   <= ovf_nxt;
      state <= state_nxt;
    end
  end

endmodule

// File: tb/tb_toggle_monitor.sv
// Bench for toggle_monitor: interval/timestamp reference model compared every cycle, plus directed literals.
module tb_toggle_monitor;

  localparam int CW   = 8;
  localparam int TOLV = 2;
  localparam int MAXV = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clear = 1'b0;
  logic [1:0]    a_in = 2'b01;
  logic [1:0]    b_in = 2'b00;
  logic [CW-1:0] a_period, b_period;
  logic          a_valid, b_valid, ovf;
  logic [1:0]    state;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ca = 0;
  int cb = 0;
  int both_seen = 0;
  bit chk_en = 1'b0;

  // reference model state: timestamps of the last event per channel
  int         m_st, m_ap, m_bp, m_last_a, m_last_b;
  bit         m_av, m_bv, m_ovf, m_arm_a, m_arm_b, m_acap;
  logic [1:0] m_prev_a, m_prev_b;

  toggle_monitor #(.CNT_W(CW), .TOL(TOLV)) dut (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .clear(clear),
    .a_period(a_period), .b_period(b_period), .a_valid(a_valid),
    .b_valid(b_valid), .state(state), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_zero();
    m_st = 0; m_ap = 0; m_bp = 0; m_av = 0; m_bv = 0; m_ovf = 0;
    m_arm_a = 0; m_arm_b = 0; m_acap = 0;
    m_last_a = cyc; m_last_b = cyc;
  endtask

  task automatic model_step();
    bit ea, eb, bad_a, bad_b, old_acap, old_arm_a, old_arm_b, ok;
    int old_ap, old_st, d;
    cyc++;
    if (rst) begin
      m_prev_a = a_in; m_prev_b = b_in;
      model_zero();
    end else begin
      ea = (a_in != m_prev_a);
      eb = (b_in != m_prev_b);
      bad_a = 1'b0; bad_b = 1'b0;
`ifdef TOGGLE_MONITOR_INVERT_CHECK_EN
      bad_a = ea && (a_in != ~m_prev_a);
      bad_b = eb && (b_in != ~m_prev_b);
`endif
      m_prev_a = a_in; m_prev_b = b_in;
      if (clear) begin
        model_zero();
      end else begin
        old_ap = m_ap; old_acap = m_acap; old_st = m_st;
        old_arm_a = m_arm_a; old_arm_b = m_arm_b;
        if ((!ea && cyc - m_last_a >= MAXV) || (!eb && cyc - m_last_b >= MAXV)) m_ovf = 1;
        m_av = 0; m_bv = 0;
        if (ea) begin
          if (m_arm_a) begin
            m_ap = (cyc - m_last_a > MAXV) ? MAXV : cyc - m_last_a;
            m_av = 1; m_acap = 1;
          end
          m_arm_a = 1; m_last_a = cyc;
        end
        if (eb) begin
          if (m_arm_b) begin
            m_bp = (cyc - m_last_b > MAXV) ? MAXV : cyc - m_last_b;
            m_bv = 1;
          end
          m_arm_b = 1; m_last_b = cyc;
        end
        d = m_bp - 2 * old_ap;
        if (d < 0) d = -d;
        ok = (d <= TOLV);
        case (old_st)
          0: if (m_arm_a && m_arm_b) m_st = 1;
          1: if (m_bv && old_acap) m_st = ok ? 2 : 3;
          2: if ((m_bv && !ok) || m_ovf) m_st = 3;
          default: m_st = 3;
        endcase
        if ((old_st == 1 || old_st == 2) && (bad_a || bad_b)) m_st = 3;
        if (old_st == 0 && ((bad_a && old_arm_a) || (bad_b && old_arm_b))) m_st = 3;
      end
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (chk_en) begin
      check("a_period", int'(a_period), m_ap);
      check("b_period", int'(b_period), m_bp);
      check("a_valid", int'(a_valid), int'(m_av));
      check("b_valid", int'(b_valid), int'(m_bv));
      check("state", int'(state), m_st);
      check("ovf", int'(ovf), int'(m_ovf));
      if (a_valid && b_valid) both_seen++;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; clear = 1'b0; a_in = 2'b01; b_in = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic step(int n, int pa, int pb);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (pa > 0) begin
        if (ca <= 1) begin a_in = ~a_in; ca = pa; end else ca--;
      end
      if (pb > 0) begin
        if (cb <= 1) begin b_in = ~b_in; cb = pb; end else cb--;
      end
    end
  endtask

  task automatic lit_outputs(string tag, int ap, int bp, int st, int ov);
    check({tag, "_a_period"}, int'(a_period), ap);
    check({tag, "_b_period"}, int'(b_period), bp);
    check({tag, "_state"}, int'(state), st);
    check({tag, "_ovf"}, int'(ovf), ov);
  endtask

  initial begin
    int pa, pb;

    // nominal 50/100 pattern locks after the second b event
    do_reset();
    lit_outputs("reset", 0, 0, 0, 0);
    check("reset_valids", int'(a_valid) + int'(b_valid), 0);
    ca = 26; cb = 1;
    step(310, 50, 100);
    lit_outputs("lock", 50, 100, 2, 0);

    // one stretched b interval (104) breaks the ratio and FAULT sticks until clear
    cb += 4;
    step(120, 50, 100);
    lit_outputs("ratio_fault", 50, 104, 3, 0);
    step(60, 50, 100);
    check("fault_sticky", int'(state), 3);
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    lit_outputs("clear", 0, 0, 0, 0);

    // a and b toggling on the same edge
    do_reset();
    both_seen = 0;
    ca = 1; cb = 1;
    step(620, 50, 100);
    lit_outputs("simul", 50, 100, 2, 0);
    check("simul_both_valid", int'(both_seen > 0), 1);

    // a held long enough to saturate its counter
    step(300, 0, 100);
    ca = 1;
    step(1, 50, 100);
    step(5, 0, 100);
    lit_outputs("ovf", 255, 100, 3, 1);

    // reset in the middle of an interval discards it
    do_reset();
    ca = 26; cb = 1;
    step(75, 50, 100);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    lit_outputs("mid_rst", 0, 0, 0, 0);
    step(40, 50, 100);
    check("mid_rst_no_capture", int'(a_period), 0);

    // non-inverting change (01 -> 11) while locked
    do_reset();
    ca = 26; cb = 1;
    step(310, 50, 100);
    check("inv_pre_state", int'(state), 2);
    @(negedge clk); a_in = a_in ^ 2'b10; ca = 50;
    @(negedge clk);
`ifdef TOGGLE_MONITOR_INVERT_CHECK_EN
    check("inv_state", int'(state), 3);
`else
    check("inv_state", int'(state), 2);
`endif

    // randomized rounds with sporadic glitches, clears and resets
    for (int r = 0; r < 10; r++) begin
      do_reset();
      pa = $urandom_range(8, 60);
      pb = (r % 4 == 3) ? $urandom_range(240, 300) : 2 * pa + $urandom_range(0, 6) - 3;
      ca = $urandom_range(1, pa);
      cb = $urandom_range(1, pb);
      for (int k = 0; k < 400; k++) begin
        step(1, pa, pb);
        if ($urandom_range(0, 299) == 0) a_in = 2'($urandom);
        if ($urandom_range(0, 299) == 0) b_in = 2'($urandom);
        clear = ($urandom_range(0, 199) == 0);
        rst   = ($urandom_range(0, 499) == 0);
      end
      @(negedge clk);
      clear = 1'b0; rst = 1'b0;
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
